// File: rtl/multicycle_sequencer_if.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer_if
//   Bundles the datapath-facing signals of the multi-cycle CPU control FSM.
//
//   master modport : the sequencer (drives enables/strobes, reads status)
//   slave  modport : the datapath / memory side
//
//   Datapath -> sequencer : opcode[5:0], alu_zero, mem_ready
//   Sequencer -> datapath : ir_we, pc_we, pc_sel[1:0], reg_we, reg_dst,
//                           mem_to_reg, alu_src, alu_op[1:0], mem_rd, mem_wr,
//                           instr_done, state[2:0], err_code[1:0],
//                           retired[CNT_W-1:0]
// ---------------------------------------------------------------------------
interface multicycle_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             alu_zero;
    logic             mem_ready;

    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             reg_we;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             mem_rd;
    logic             mem_wr;
    logic             instr_done;
    logic [2:0]       state;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, alu_zero, mem_ready,
        output ir_we, pc_we, pc_sel, reg_we, reg_dst, mem_to_reg, alu_src,
               alu_op, mem_rd, mem_wr, instr_done, state, err_code, retired
    );

    modport slave (
        output opcode, alu_zero, mem_ready,
        input  ir_we, pc_we, pc_sel, reg_we, reg_dst, mem_to_reg, alu_src,
               alu_op, mem_rd, mem_wr, instr_done, state, err_code, retired
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//   Opcode-aware main control FSM for the multi-cycle CPU datapath.
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with a sticky ERROR
//   state for illegal opcodes and data-memory timeouts. Counts retired
//   instructions (one per instr_done pulse, wrapping).
//
//   Ports:
//     clk        in   system clock, rising edge
//     nreset     in   asynchronous, ACTIVE-HIGH reset (despite the name)
//     run, step  in   only when MC_SEQ_SINGLE_STEP_EN is defined
//     bus        master modport of multicycle_sequencer_if (opcode, alu_zero,
//                mem_ready in; enables, strobes, state, err_code, retired out)
//
//   Parameters:
//     CNT_W        width of the retired-instruction counter
//     MEM_TIMEOUT  MEM cycles without mem_ready before a timeout error (1..255)
//
//   Configuration macro:
//     MC_SEQ_SINGLE_STEP_EN  adds run/step single-step control. Without it the
//                            sequencer always runs freely.
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  nreset,
`ifdef MC_SEQ_SINGLE_STEP_EN
    input  logic                  run,
    input  logic                  step,
`endif
    multicycle_sequencer_if.master bus
);

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Wait count at which the current no-ready MEM cycle is the last allowed.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [7:0]       wait_q, wait_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    // Combinational control, before reset gating.
    logic       ir_we_c, pc_we_c, reg_we_c, reg_dst_c, mem_to_reg_c;
    logic       alu_src_c, mem_rd_c, mem_wr_c, instr_done_c;
    logic [1:0] pc_sel_c, alu_op_c;

    // FETCH may start a new instruction this cycle.
    logic go;
`ifdef MC_SEQ_SINGLE_STEP_EN
    // With run low, a step pulse releases exactly one FETCH; step seen in any
    // other state has no effect because only FETCH looks at go.
    assign go = run | step;
`else
    assign go = 1'b1;
`endif

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            err_q     <= ERR_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wait_d       = wait_q;
        err_d        = err_q;
        ir_we_c      = 1'b0;
        pc_we_c      = 1'b0;
        pc_sel_c     = 2'b00;
        reg_we_c     = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_c    = 1'b0;
        alu_op_c     = 2'b00;
        mem_rd_c     = 1'b0;
        mem_wr_c     = 1'b0;
        instr_done_c = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (go) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                // The live opcode is decoded here; op_q holds it for later states.
                op_d = bus.opcode;
                case (bus.opcode)
                    OP_J: begin
                        pc_we_c      = 1'b1;
                        pc_sel_c     = 2'b10;
                        instr_done_c = 1'b1;
                        state_d      = S_FETCH;
                    end
                    OP_R, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
                    default: begin
                        err_d   = ERR_ILLEGAL;
                        state_d = S_ERROR;
                    end
                endcase
            end

            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        alu_op_c = 2'b10;
                        state_d  = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_c = 1'b1;
                        wait_d    = '0;
                        state_d   = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op_c     = 2'b01;
                        pc_we_c      = 1'b1;
                        pc_sel_c     = {1'b0, bus.alu_zero};
                        instr_done_c = 1'b1;
                        state_d      = S_FETCH;
                    end
                    default: begin
                        // op_q was screened in DECODE; treat corruption as illegal.
                        err_d   = ERR_ILLEGAL;
                        state_d = S_ERROR;
                    end
                endcase
            end

            S_MEM: begin
                alu_src_c = 1'b1;
                mem_rd_c  = (op_q == OP_LW);
                mem_wr_c  = (op_q == OP_SW);
                if (bus.mem_ready) begin
                    if (op_q == OP_SW) begin
                        pc_we_c      = 1'b1;
                        instr_done_c = 1'b1;
                        state_d      = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // ERROR drives no strobes, so mem_rd/mem_wr fall on this edge.
                    err_d   = ERR_TIMEOUT;
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_WB: begin
                reg_we_c     = 1'b1;
                reg_dst_c    = (op_q == OP_R);
                mem_to_reg_c = (op_q == OP_LW);
                pc_we_c      = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end

            S_ERROR: begin
                // Sticky: only reset leaves this state.
            end

            default: state_d = S_ERROR;
        endcase
    end

    assign retired_d = retired_q + CNT_W'(instr_done_c);

    // Reset forces every enable low at once rather than waiting for a clock
    // edge, so a reset asserted mid-access drops mem_rd/mem_wr immediately.
    assign bus.ir_we      = ir_we_c      & ~nreset;
    assign bus.pc_we      = pc_we_c      & ~nreset;
    assign bus.pc_sel     = pc_sel_c     & {2{~nreset}};
    assign bus.reg_we     = reg_we_c     & ~nreset;
    assign bus.reg_dst    = reg_dst_c    & ~nreset;
    assign bus.mem_to_reg = mem_to_reg_c & ~nreset;
    assign bus.alu_src    = alu_src_c    & ~nreset;
    assign bus.alu_op     = alu_op_c     & {2{~nreset}};
    assign bus.mem_rd     = mem_rd_c     & ~nreset;
    assign bus.mem_wr     = mem_wr_c     & ~nreset;
    assign bus.instr_done = instr_done_c & ~nreset;
    assign bus.state      = state_q;
    assign bus.err_code   = err_q;
    assign bus.retired    = retired_q;

endmodule
